pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have inputs: id_rs, id_rt  input  5 each  source register numbers of the instruction in decode.
REQ-004 SHALL have inputs: ex_AW (5), ex_regwrite (1), ex_memtoreg (1)  destination register and controls held in the ID/EX buffer.
REQ-005 SHALL have inputs: mem_AW (5), mem_regwrite (1)  destination and write enable held in the EX/MEM buffer.
REQ-006 SHALL have inputs: wb_AW (5), wb_regwrite (1)  out_AW and out_regwrite from the MEM/WB buffer.
REQ-007 SHALL have inputs: branch_taken (1)  branch resolved taken in EX; mem_req (1), mem_ready (1)  data-memory access handshake.
REQ-008 SHALL have outputs: pc_en, buf1_en, buf2_en, buf3_en, buf4_en  output  1 each  load enables for the PC and the four pipeline buffers.
REQ-009 SHALL have outputs: buf1_flush, buf2_flush  output  1 each  load a bubble (all controls 0) into IF/ID and ID/EX.
REQ-010 SHALL have outputs: fwd_a, fwd_b  output  2 each  ALU operand select: 00 register file, 01 from EX/MEM, 10 from MEM/WB.
REQ-011 SHALL have outputs: stall_cnt, flush_cnt  output  16 each  saturating event counters.

Function
REQ-012 SHALL implement FSM states RUN, LU_STALL, MEM_WAIT, FLUSH, encoded in 2 bits.
REQ-013 Load-use hazard SHALL be: ex_memtoreg & ex_regwrite & ex_AW!=0 & (ex_AW==id_rs | ex_AW==id_rt).
REQ-014 Transition priority out of RUN and LU_STALL SHALL be: mem_req&!mem_ready -> MEM_WAIT; else branch_taken -> FLUSH; else load-use -> LU_STALL; else RUN.
REQ-015 In RUN, all enables SHALL be 1 and both flushes 0.
REQ-016 In LU_STALL (exactly one cycle), pc_en=buf1_en=0, buf2_flush=1, buf3_en=buf4_en=1; next state SHALL be RUN, evaluated per REQ-014.
REQ-017 In MEM_WAIT, all five enables SHALL be 0 and flushes 0; the state SHALL hold until mem_ready=1, then return to RUN.
REQ-018 A branch_taken pulse during MEM_WAIT SHALL be captured in a pending bit and SHALL cause FLUSH on the cycle after MEM_WAIT exits.
REQ-019 In FLUSH (exactly one cycle), all enables SHALL be 1 and buf1_flush=buf2_flush=1; next state SHALL be RUN; a simultaneous load-use SHALL be discarded.
REQ-020 fwd_a (for id_rs; fwd_b for id_rt) SHALL be 01 if mem_regwrite & mem_AW!=0 & mem_AW matches; else 10 if wb_regwrite & wb_AW!=0 & wb_AW matches; else 00.
REQ-021 Forwarding SHALL be combinational, zero latency, and independent of FSM state.
REQ-022 stall_cnt SHALL increment by 1 on each cycle spent in LU_STALL or MEM_WAIT and saturate at 16'hFFFF.
REQ-023 flush_cnt SHALL increment by 1 on each cycle spent in FLUSH and saturate at 16'hFFFF.
REQ-024 Register 0 SHALL never cause a hazard or forward.

Reset
REQ-025 rst_n=0 SHALL immediately force state RUN, pending bit 0, stall_cnt=0, flush_cnt=0.
REQ-026 While in reset, outputs SHALL be the RUN values: enables 1, flushes 0; fwd_a and fwd_b SHALL follow REQ-020.
REQ-027 Reset asserted mid-MEM_WAIT or mid-FLUSH SHALL abandon the operation with no residual stall.

Structure
REQ-028 State encodings and fwd_* select codes SHALL be constants in the shared pipeline package.
REQ-029 Forwarding comparison SHALL be one sub-module, fwd_sel, instantiated twice (operand A and operand B).

Verification
REQ-030 Load-use: ex_memtoreg=1, ex_regwrite=1, ex_AW=5, id_rs=5 -> one cycle with pc_en=0, buf1_en=0, buf2_flush=1; stall_cnt 0->1.
REQ-031 Memory wait: mem_req=1 with mem_ready=0 for 3 cycles -> all enables 0 for 3 cycles; RUN on the cycle after mem_ready=1; stall_cnt=3.
REQ-032 Branch during MEM_WAIT: branch_taken pulsed in the 2nd wait cycle -> FLUSH one cycle after exit; flush_cnt=1.
REQ-033 Forward priority: mem_AW=wb_AW=7, both regwrite=1, id_rt=7 -> fwd_b=01; mem_regwrite=0 -> fwd_b=10; id_rt=0 -> fwd_b=00.
REQ-034 Simultaneous branch_taken and load-use -> FLUSH only, no LU_STALL afterwards.
REQ-035 Async reset: rst_n low mid-MEM_WAIT, away from a clock edge -> enables 1 and both counters 0 before the next clk edge.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline constants: hazard FSM states, operand-forwarding selects,
// field widths and a saturating counter helper.
package pipe_hazard_ctrl_pkg;

   localparam int REG_W = 5;
   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_LU_STALL = 2'd1,
      ST_MEM_WAIT = 2'd2,
      ST_FLUSH    = 2'd3
   } state_e;

   // ALU operand source selects.
   localparam logic [1:0] FWD_RF    = 2'b00;  // register file
   localparam logic [1:0] FWD_EXMEM = 2'b01;  // EX/MEM result
   localparam logic [1:0] FWD_MEMWB = 2'b10;  // MEM/WB result

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller
// (slave): register tags and controls in, stall/flush/forward controls out.
interface pipe_hazard_ctrl_if;
   import pipe_hazard_ctrl_pkg::*;

   logic [REG_W-1:0] id_rs, id_rt, ex_AW, mem_AW, wb_AW;
   logic             ex_regwrite, ex_memtoreg, mem_regwrite, wb_regwrite;
   logic             branch_taken, mem_req, mem_ready;
   logic             pc_en, buf1_en, buf2_en, buf3_en, buf4_en;
   logic             buf1_flush, buf2_flush;
   logic [1:0]       fwd_a, fwd_b;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   modport master (
      output id_rs, id_rt, ex_AW, ex_regwrite, ex_memtoreg, mem_AW, mem_regwrite,
             wb_AW, wb_regwrite, branch_taken, mem_req, mem_ready,
      input  pc_en, buf1_en, buf2_en, buf3_en, buf4_en, buf1_flush, buf2_flush,
             fwd_a, fwd_b, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rs, id_rt, ex_AW, ex_regwrite, ex_memtoreg, mem_AW, mem_regwrite,
             wb_AW, wb_regwrite, branch_taken, mem_req, mem_ready,
      output pc_en, buf1_en, buf2_en, buf3_en, buf4_en, buf1_flush, buf2_flush,
             fwd_a, fwd_b, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Operand forwarding select for one ALU source register. Purely combinational.
module fwd_sel
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] src,
   input  logic [REG_W-1:0] mem_aw,
   input  logic             mem_regwrite,
   input  logic [REG_W-1:0] wb_aw,
   input  logic             wb_regwrite,
   output logic [1:0]       sel
);

   // Youngest producer wins; register 0 is hard-wired and never forwarded.
   always_comb begin
      // NOTE: default every output first so no path leaves it unassigned (no latch).
      sel = FWD_RF;
      if (src != '0 && mem_regwrite && mem_aw == src) begin
         sel = FWD_EXMEM;
      end else if (src != '0 && wb_regwrite && wb_aw == src) begin
         sel = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, memory wait, branch flush,
// operand forwarding and saturating stall/flush event counters.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
(
   input logic                clk,
   input logic                rst_n,
   pipe_hazard_ctrl_if.slave  hz
);

   state_e           state_q, state_d;
   logic             pend_q, pend_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             load_use, mem_stall;

   fwd_sel u_fwd_a (
      .src(hz.id_rs), .mem_aw(hz.mem_AW), .mem_regwrite(hz.mem_regwrite),
      .wb_aw(hz.wb_AW), .wb_regwrite(hz.wb_regwrite), .sel(hz.fwd_a)
   );

   fwd_sel u_fwd_b (
      .src(hz.id_rt), .mem_aw(hz.mem_AW), .mem_regwrite(hz.mem_regwrite),
      .wb_aw(hz.wb_AW), .wb_regwrite(hz.wb_regwrite), .sel(hz.fwd_b)
   );

   assign load_use  = hz.ex_memtoreg & hz.ex_regwrite & (hz.ex_AW != '0) &
                      ((hz.ex_AW == hz.id_rs) | (hz.ex_AW == hz.id_rt));
   assign mem_stall = hz.mem_req & ~hz.mem_ready;

   // Next state; a branch seen while memory-stalled is parked in pend until RUN.
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      case (state_q)
         ST_RUN, ST_LU_STALL: begin
            if (mem_stall) begin
               state_d = ST_MEM_WAIT;
            end else if (hz.branch_taken || pend_q) begin
               state_d = ST_FLUSH;
               pend_d  = 1'b0;
            end else if (load_use) begin
               state_d = ST_LU_STALL;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_MEM_WAIT: begin
            pend_d = pend_q | hz.branch_taken;
            if (hz.mem_ready) state_d = ST_RUN;
         end
         ST_FLUSH: state_d = ST_RUN;  // any load-use is inside the squashed slot
         default:  state_d = ST_RUN;
      endcase
   end

   // Moore control outputs decoded from the current state.
   always_comb begin
      hz.pc_en      = 1'b1;
      hz.buf1_en    = 1'b1;
      hz.buf2_en    = 1'b1;
      hz.buf3_en    = 1'b1;
      hz.buf4_en    = 1'b1;
      hz.buf1_flush = 1'b0;
      hz.buf2_flush = 1'b0;
      case (state_q)
         ST_LU_STALL: begin
            hz.pc_en      = 1'b0;
            hz.buf1_en    = 1'b0;
            hz.buf2_flush = 1'b1;
         end
         ST_MEM_WAIT: begin
            hz.pc_en   = 1'b0;
            hz.buf1_en = 1'b0;
            hz.buf2_en = 1'b0;
            hz.buf3_en = 1'b0;
            hz.buf4_en = 1'b0;
         end
         ST_FLUSH: begin
            hz.buf1_flush = 1'b1;
            hz.buf2_flush = 1'b1;
         end
         default: ;
      endcase
   end

   // Event counters advance once per cycle spent in the counted states.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (state_q == ST_LU_STALL || state_q == ST_MEM_WAIT) stall_cnt_d = sat_inc(stall_cnt_q);
      if (state_q == ST_FLUSH) flush_cnt_d = sat_inc(flush_cnt_q);
   end

   // State register; async reset abandons any stall or pending flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         pend_q      <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values.
         state_q     <= state_d;
         pend_q      <= pend_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign hz.stall_cnt = stall_cnt_q;
   assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a random
// run checked against a cycle-level behavioural model of the control rules.
module tb_pipe_hazard_ctrl;

   logic clk;
   logic rst_n;

   pipe_hazard_ctrl_if hif();

   pipe_hazard_ctrl dut (.clk(clk), .rst_n(rst_n), .hz(hif));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Model phases and the control pattern each one must show:
   // {pc_en, buf1_en, buf2_en, buf3_en, buf4_en, buf1_flush, buf2_flush}
   localparam int P_RUN = 0, P_LU = 1, P_WAIT = 2, P_FLUSH = 3;
   localparam logic [6:0] C_RUN   = 7'b11111_00;
   localparam logic [6:0] C_LU    = 7'b00111_01;
   localparam logic [6:0] C_WAIT  = 7'b00000_00;
   localparam logic [6:0] C_FLUSH = 7'b11111_11;

   int m_ph;
   bit m_pend;
   int m_stall;
   int m_flush;

   function automatic logic [6:0] exp_ctl();
      case (m_ph)
         P_LU:    return C_LU;
         P_WAIT:  return C_WAIT;
         P_FLUSH: return C_FLUSH;
         default: return C_RUN;
      endcase
   endfunction

   function automatic logic [6:0] get_ctl();
      return {hif.pc_en, hif.buf1_en, hif.buf2_en, hif.buf3_en, hif.buf4_en,
              hif.buf1_flush, hif.buf2_flush};
   endfunction

   function automatic logic [1:0] exp_fwd(input int src, input int maw, input bit mwe,
                                          input int waw, input bit wwe);
      if (src != 0 && mwe && maw == src) return 2'b01;
      if (src != 0 && wwe && waw == src) return 2'b10;
      return 2'b00;
   endfunction

   task automatic model_reset();
      m_ph = P_RUN; m_pend = 0; m_stall = 0; m_flush = 0;
   endtask

   task automatic idle();
      hif.id_rs = '0; hif.id_rt = '0; hif.ex_AW = '0; hif.mem_AW = '0; hif.wb_AW = '0;
      hif.ex_regwrite = 0; hif.ex_memtoreg = 0; hif.mem_regwrite = 0; hif.wb_regwrite = 0;
      hif.branch_taken = 0; hif.mem_req = 0; hif.mem_ready = 1;
   endtask

   task automatic do_reset();
      @(negedge clk); rst_n = 0;
      @(negedge clk); rst_n = 1;
      model_reset();
   endtask

   // Advance one clock: model consumes the current inputs, then DUT is sampled at edge+1.
   task automatic step();
      int  ph_n;
      bit  pend_n, lu, stall_req, br;
      lu = hif.ex_memtoreg && hif.ex_regwrite && hif.ex_AW != 0 &&
           (hif.ex_AW == hif.id_rs || hif.ex_AW == hif.id_rt);
      stall_req = hif.mem_req && !hif.mem_ready;
      br = hif.branch_taken;
      pend_n = m_pend;
      if (m_ph == P_FLUSH) ph_n = P_RUN;
      else if (m_ph == P_WAIT) begin
         pend_n = m_pend | br;
         ph_n = hif.mem_ready ? P_RUN : P_WAIT;
      end
      else if (stall_req) ph_n = P_WAIT;
      else if (br || m_pend) begin ph_n = P_FLUSH; pend_n = 0; end
      else if (lu) ph_n = P_LU;
      else ph_n = P_RUN;
      if ((m_ph == P_LU || m_ph == P_WAIT) && m_stall < 65535) m_stall++;
      if (m_ph == P_FLUSH && m_flush < 65535) m_flush++;
      @(posedge clk); #1;
      m_ph = ph_n; m_pend = pend_n;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 0;
      hif.id_rs = 5'd3; hif.mem_AW = 5'd3; hif.mem_regwrite = 1;
      #12;
      n_cmp++; if (get_ctl() !== C_RUN) begin n_err++; $display("FAIL reset_ctl: got %b want %b", get_ctl(), C_RUN); end
      n_cmp++; if (hif.stall_cnt !== 16'd0) begin n_err++; $display("FAIL reset_stall_cnt: got %0d want 0", hif.stall_cnt); end
      n_cmp++; if (hif.flush_cnt !== 16'd0) begin n_err++; $display("FAIL reset_flush_cnt: got %0d want 0", hif.flush_cnt); end
      n_cmp++; if (hif.fwd_a !== 2'b01) begin n_err++; $display("FAIL reset_fwd_a: got %b want 01", hif.fwd_a); end
      idle();
      @(negedge clk); rst_n = 1;
      model_reset();
   endtask

   task automatic test_load_use();
      do_reset(); idle();
      hif.ex_memtoreg = 1; hif.ex_regwrite = 1; hif.ex_AW = 5'd5; hif.id_rs = 5'd5;
      step();
      hif.ex_memtoreg = 0; hif.ex_regwrite = 0; hif.ex_AW = 0;
      n_cmp++; if (get_ctl() !== C_LU) begin n_err++; $display("FAIL lu_ctl: got %b want %b", get_ctl(), C_LU); end
      n_cmp++; if (hif.stall_cnt !== 16'd0) begin n_err++; $display("FAIL lu_cnt0: got %0d want 0", hif.stall_cnt); end
      step();
      n_cmp++; if (get_ctl() !== C_RUN) begin n_err++; $display("FAIL lu_release: got %b want %b", get_ctl(), C_RUN); end
      n_cmp++; if (hif.stall_cnt !== 16'd1) begin n_err++; $display("FAIL lu_cnt1: got %0d want 1", hif.stall_cnt); end
      // ex_AW = 0 must never stall
      hif.ex_memtoreg = 1; hif.ex_regwrite = 1; hif.ex_AW = 5'd0; hif.id_rs = 5'd0;
      step();
      n_cmp++; if (get_ctl() !== C_RUN) begin n_err++; $display("FAIL lu_reg0: got %b want %b", get_ctl(), C_RUN); end
      idle();
   endtask

   task automatic test_mem_wait();
      do_reset(); idle();
      hif.mem_req = 1; hif.mem_ready = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++; if (get_ctl() !== C_WAIT) begin n_err++; $display("FAIL wait_ctl[%0d]: got %b want %b", i, get_ctl(), C_WAIT); end
      end
      hif.mem_ready = 1;
      step();
      hif.mem_req = 0;
      n_cmp++; if (get_ctl() !== C_RUN) begin n_err++; $display("FAIL wait_exit: got %b want %b", get_ctl(), C_RUN); end
      n_cmp++; if (hif.stall_cnt !== 16'd3) begin n_err++; $display("FAIL wait_cnt: got %0d want 3", hif.stall_cnt); end
   endtask

   task automatic test_branch_in_wait();
      do_reset(); idle();
      hif.mem_req = 1; hif.mem_ready = 0;
      step(); step();
      hif.branch_taken = 1;
      step();
      hif.branch_taken = 0; hif.mem_ready = 1;
      n_cmp++; if (get_ctl() !== C_WAIT) begin n_err++; $display("FAIL bw_hold: got %b want %b", get_ctl(), C_WAIT); end
      step();
      hif.mem_req = 0;
      n_cmp++; if (get_ctl() !== C_RUN) begin n_err++; $display("FAIL bw_exit: got %b want %b", get_ctl(), C_RUN); end
      step();
      n_cmp++; if (get_ctl() !== C_FLUSH) begin n_err++; $display("FAIL bw_flush: got %b want %b", get_ctl(), C_FLUSH); end
      step();
      n_cmp++; if (get_ctl() !== C_RUN) begin n_err++; $display("FAIL bw_after: got %b want %b", get_ctl(), C_RUN); end
      n_cmp++; if (hif.flush_cnt !== 16'd1) begin n_err++; $display("FAIL bw_flush_cnt: got %0d want 1", hif.flush_cnt); end
   endtask

   task automatic test_branch_and_lu();
      do_reset(); idle();
      hif.ex_memtoreg = 1; hif.ex_regwrite = 1; hif.ex_AW = 5'd9; hif.id_rt = 5'd9;
      hif.branch_taken = 1;
      step();
      hif.branch_taken = 0;
      n_cmp++; if (get_ctl() !== C_FLUSH) begin n_err++; $display("FAIL blu_flush: got %b want %b", get_ctl(), C_FLUSH); end
      step();
      n_cmp++; if (get_ctl() !== C_RUN) begin n_err++; $display("FAIL blu_no_stall: got %b want %b", get_ctl(), C_RUN); end
      n_cmp++; if (hif.stall_cnt !== 16'd0) begin n_err++; $display("FAIL blu_stall_cnt: got %0d want 0", hif.stall_cnt); end
      n_cmp++; if (hif.flush_cnt !== 16'd1) begin n_err++; $display("FAIL blu_flush_cnt: got %0d want 1", hif.flush_cnt); end
      idle();
   endtask

   task automatic test_forward();
      idle();
      hif.mem_AW = 5'd7; hif.wb_AW = 5'd7; hif.mem_regwrite = 1; hif.wb_regwrite = 1; hif.id_rt = 5'd7;
      #1;
      n_cmp++; if (hif.fwd_b !== 2'b01) begin n_err++; $display("FAIL fwd_mem: got %b want 01", hif.fwd_b); end
      hif.mem_regwrite = 0; #1;
      n_cmp++; if (hif.fwd_b !== 2'b10) begin n_err++; $display("FAIL fwd_wb: got %b want 10", hif.fwd_b); end
      hif.id_rt = 5'd0; #1;
      n_cmp++; if (hif.fwd_b !== 2'b00) begin n_err++; $display("FAIL fwd_none: got %b want 00", hif.fwd_b); end
      hif.mem_AW = 5'd0; hif.wb_AW = 5'd0; hif.mem_regwrite = 1; hif.id_rs = 5'd0; #1;
      n_cmp++; if (hif.fwd_a !== 2'b00) begin n_err++; $display("FAIL fwd_reg0: got %b want 00", hif.fwd_a); end
      idle();
   endtask

   task automatic test_async_reset();
      do_reset(); idle();
      hif.mem_req = 1; hif.mem_ready = 0;
      step(); step();
      #3 rst_n = 0;
      #1;
      n_cmp++; if (get_ctl() !== C_RUN) begin n_err++; $display("FAIL arst_ctl: got %b want %b", get_ctl(), C_RUN); end
      n_cmp++; if (hif.stall_cnt !== 16'd0) begin n_err++; $display("FAIL arst_stall_cnt: got %0d want 0", hif.stall_cnt); end
      n_cmp++; if (hif.flush_cnt !== 16'd0) begin n_err++; $display("FAIL arst_flush_cnt: got %0d want 0", hif.flush_cnt); end
      idle();
      @(negedge clk); rst_n = 1;
      model_reset();
      step();
      n_cmp++; if (get_ctl() !== C_RUN) begin n_err++; $display("FAIL arst_residual: got %b want %b", get_ctl(), C_RUN); end
   endtask

   task automatic test_random();
      logic [1:0] ea, eb;
      do_reset(); idle();
      for (int i = 0; i < 2000; i++) begin
         hif.id_rs = 5'($urandom_range(0, 7));  hif.id_rt = 5'($urandom_range(0, 7));
         hif.ex_AW = 5'($urandom_range(0, 7));  hif.mem_AW = 5'($urandom_range(0, 7));
         hif.wb_AW = 5'($urandom_range(0, 7));
         hif.ex_memtoreg = 1'($urandom_range(0, 1)); hif.ex_regwrite = 1'($urandom_range(0, 1));
         hif.mem_regwrite = 1'($urandom_range(0, 1)); hif.wb_regwrite = 1'($urandom_range(0, 1));
         hif.branch_taken = ($urandom_range(0, 7) == 0);
         hif.mem_req = ($urandom_range(0, 3) == 0);
         hif.mem_ready = ($urandom_range(0, 1) == 0);
         #1;
         ea = exp_fwd(int'(hif.id_rs), int'(hif.mem_AW), hif.mem_regwrite, int'(hif.wb_AW), hif.wb_regwrite);
         eb = exp_fwd(int'(hif.id_rt), int'(hif.mem_AW), hif.mem_regwrite, int'(hif.wb_AW), hif.wb_regwrite);
         n_cmp++; if (hif.fwd_a !== ea) begin n_err++; $display("FAIL rnd_fwd_a[%0d]: got %b want %b", i, hif.fwd_a, ea); end
         n_cmp++; if (hif.fwd_b !== eb) begin n_err++; $display("FAIL rnd_fwd_b[%0d]: got %b want %b", i, hif.fwd_b, eb); end
         step();
         n_cmp++; if (get_ctl() !== exp_ctl()) begin n_err++; $display("FAIL rnd_ctl[%0d]: got %b want %b", i, get_ctl(), exp_ctl()); end
         n_cmp++; if (hif.stall_cnt !== 16'(m_stall)) begin n_err++; $display("FAIL rnd_stall_cnt[%0d]: got %0d want %0d", i, hif.stall_cnt, m_stall); end
         n_cmp++; if (hif.flush_cnt !== 16'(m_flush)) begin n_err++; $display("FAIL rnd_flush_cnt[%0d]: got %0d want %0d", i, hif.flush_cnt, m_flush); end
      end
      idle();
   endtask

   task automatic test_saturation();
      do_reset(); idle();
      hif.mem_req = 1; hif.mem_ready = 0;
      for (int i = 0; i < 65540; i++) step();
      n_cmp++; if (hif.stall_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_stall: got %h want ffff", hif.stall_cnt); end
      hif.mem_ready = 1;
      step();
      n_cmp++; if (hif.stall_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold: got %h want ffff", hif.stall_cnt); end
      n_cmp++; if (hif.stall_cnt !== 16'(m_stall)) begin n_err++; $display("FAIL sat_model: got %h want %h", hif.stall_cnt, m_stall); end
      idle();
   endtask

   initial begin
      rst_n = 0;
      model_reset();
      test_reset();
      test_load_use();
      test_mem_wait();
      test_branch_in_wait();
      test_branch_and_lu();
      test_forward();
      test_async_reset();
      test_random();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
